sdram_frame_sched: RTL and testbench

Burst scheduler sharing one SDRAM controller command port between the frame writer (write FIFO, filled from the pattern/video source) and the display reader (read FIFO, drained by the VGA controller). It runs in the SDRAM clock domain, double-buffers two frame regions (ping-pong), and swaps them on frame sync. Read bursts take priority so the display never underruns; an optional guard bounds write starvation.

---
 rtl/sdram_frame_sched.sv | 162 ++++++++++++++++
 tb/tb_sdram_frame_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
// Shares one SDRAM burst port between frame writer and display reader (ping-pong buffers, read priority).
// Grant registered one cycle after IDLE eligibility; fields held until cmd_ready; FRAME_SCHED_STARVE_GUARD_EN bounds write starvation.
module sdram_frame_sched #(
   parameter int ADDR_W      = 22,
   parameter int FRAME_WORDS = 786432,
   parameter int BURST_LEN   = 256,
   parameter int LVL_W       = 10,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic              frame_sync,
   input  logic [LVL_W-1:0]  wr_fifo_level,
   input  logic [LVL_W-1:0]  rd_fifo_space,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [8:0]        cmd_len,
   input  logic              cmd_done,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              wr_frame_done,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_LEN);
   localparam logic [LVL_W:0]    BURST_LVL = (LVL_W + 1)'(BURST_LEN);
   localparam logic [8:0]        LEN_VAL   = 9'(BURST_LEN);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr_adv;
   logic [ADDR_W-1:0] rd_ptr_adv;
   logic              sync_pend;
   logic              we;
   logic              re;
   logic              grant_go;
   logic              pick_wr;
   logic              force_wr;

   assign we = ({1'b0, wr_fifo_level} >= BURST_LVL) && (wr_ptr < FRAME_END);
   assign re = ({1'b0, rd_fifo_space} >= BURST_LVL);

   // A sync seen in IDLE takes this cycle for the swap, so arbitration waits one cycle
   // and the next grant already uses the swapped bank/pointers.
   assign grant_go = (state == IDLE) && init_done && !frame_sync && (re || we);
   assign pick_wr  = force_wr || !re;

`ifdef FRAME_SCHED_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0] starve_cnt;

   assign force_wr = we && (starve_cnt >= SC_W'(STARVE_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (!we) begin
            starve_cnt <= '0;
         end else if (grant_go) begin
            if (pick_wr) starve_cnt <= '0;
            else         starve_cnt <= starve_cnt + SC_W'(1);
         end
      end
   end
`else
   logic unused_starve_cfg;

   assign force_wr          = 1'b0;
   assign unused_starve_cfg = (STARVE_MAX > 0);
`endif

   always_comb begin
      wr_ptr_adv = wr_ptr;
      rd_ptr_adv = rd_ptr;
      if (cmd_wr) begin
         wr_ptr_adv = (wr_ptr + BURST_INC >= FRAME_END) ? FRAME_END : wr_ptr + BURST_INC;
      end else begin
         rd_ptr_adv = (rd_ptr + BURST_INC >= FRAME_END) ? '0 : rd_ptr + BURST_INC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         sync_pend     <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_wr        <= 1'b0;
         cmd_addr      <= '0;
         cmd_len       <= '0;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b1;
         wr_frame_done <= 1'b0;
         busy          <= 1'b0;
      end else begin
         wr_frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_sync) begin
                  if (wr_ptr == FRAME_END) begin
                     rd_bank <= wr_bank;
                     wr_bank <= ~wr_bank;
                     wr_ptr  <= '0;
                  end
                  rd_ptr <= '0;
               end else if (grant_go) begin
                  cmd_wr    <= pick_wr;
                  cmd_addr  <= pick_wr ? {wr_bank, wr_ptr[ADDR_W-2:0]}
                                       : {rd_bank, rd_ptr[ADDR_W-2:0]};
                  cmd_len   <= LEN_VAL;
                  cmd_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (frame_sync) sync_pend <= 1'b1;
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cmd_done) begin
                  if (cmd_wr && (wr_ptr_adv == FRAME_END)) wr_frame_done <= 1'b1;
                  // Pointer advance lands first; the swap test sees the advanced write pointer.
                  if (sync_pend || frame_sync) begin
                     if (wr_ptr_adv == FRAME_END) begin
                        rd_bank <= wr_bank;
                        wr_bank <= ~wr_bank;
                        wr_ptr  <= '0;
                     end else begin
                        wr_ptr <= wr_ptr_adv;
                     end
                     rd_ptr <= '0;
                  end else begin
                     wr_ptr <= wr_ptr_adv;
                     rd_ptr <= rd_ptr_adv;
                  end
                  sync_pend <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (frame_sync) begin
                  sync_pend <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Scoreboard bench for sdram_frame_sched with a 1024-word frame and a simple command-port responder.
`timescale 1ns/1ps
module tb_sdram_frame_sched;

   localparam int ADDR_W = 22;
   localparam int FW     = 1024;
   localparam int BL     = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              init_done = 1'b0;
   logic              frame_sync = 1'b0;
   logic [9:0]        wr_fifo_level = '0;
   logic [9:0]        rd_fifo_space = '0;
   logic              cmd_valid;
   logic              cmd_ready = 1'b0;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [8:0]        cmd_len;
   logic              cmd_done = 1'b0;
   logic              wr_bank;
   logic              rd_bank;
   logic              wr_frame_done;
   logic              busy;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

   cmd_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   sdram_frame_sched #(
      .ADDR_W(ADDR_W), .FRAME_WORDS(FW), .BURST_LEN(BL), .LVL_W(10), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .frame_sync(frame_sync),
      .wr_fifo_level(wr_fifo_level), .rd_fifo_space(rd_fifo_space),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
      .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_frame_done(wr_frame_done), .busy(busy)
   );

   // Controller responder: waits for a command, holds ready low, accepts, then pulses done.
   task automatic serve(input int rdy_dly, input int done_dly, output logic got, output logic o_wr,
                        output logic [ADDR_W-1:0] o_addr, output logic [8:0] o_len, output logic held);
      int n;
      n = 0; got = 1'b0; held = 1'b1; o_wr = 1'b0; o_addr = '0; o_len = '0;
      while (cmd_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (cmd_valid === 1'b1) begin
         got = 1'b1; o_wr = cmd_wr; o_addr = cmd_addr; o_len = cmd_len;
         for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_wr !== o_wr || cmd_addr !== o_addr || cmd_len !== o_len)
               held = 1'b0;
         end
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         for (int i = 0; i < done_dly; i++) @(negedge clk);
         cmd_done = 1'b1;
         @(negedge clk);
         cmd_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({cmd_valid, cmd_wr, cmd_addr, cmd_len, busy} !== {1'b0, 1'b0, 22'h0, 9'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_cmd got valid=%b wr=%b addr=%h len=%0d busy=%b exp all 0",
                  cmd_valid, cmd_wr, cmd_addr, cmd_len, busy);
      end
      n_cmp++;
      if ({wr_bank, rd_bank, wr_frame_done} !== 3'b010) begin
         n_err++;
         $display("FAIL reset_banks got wr_bank=%b rd_bank=%b wfd=%b exp 0 1 0", wr_bank, rd_bank, wr_frame_done);
      end
      rst = 1'b0; init_done = 1'b1; rd_fifo_space = 10'd512; wr_fifo_level = 10'd0;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (cmd_valid !== 1'b1) begin
         n_err++;
         $display("FAIL issue_before_reset got valid=%b exp 1", cmd_valid);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_bank, rd_bank, wr_frame_done, busy} !==
          {1'b0, 1'b0, 22'h0, 9'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid_issue got valid=%b addr=%h len=%0d rd_bank=%b busy=%b exp 0 0 0 1 0",
                  cmd_valid, cmd_addr, cmd_len, rd_bank, busy);
      end
      @(negedge clk);
      init_done = 1'b0; wr_fifo_level = 10'd300; rd_fifo_space = 10'd512; rst = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0) n++;
      end
      n_cmp++;
      if (n !== 0) begin
         n_err++;
         $display("FAIL init_low_idle got %0d valid cycles exp 0", n);
      end
   endtask

   task automatic test_read_priority();
      logic got, w, held;
      logic [ADDR_W-1:0] a;
      logic [8:0] l;
      cmd_t e;
      init_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({cmd_valid, busy} !== 2'b11) begin
         n_err++;
         $display("FAIL rd_prio_latency got valid=%b busy=%b exp 1 1", cmd_valid, busy);
      end
      sb.push_back({1'b0, 22'h200000});
      serve(3, 2, got, w, a, l, held);
      e = sb.pop_front();
      n_cmp++;
      if (!got || w !== e.wr || a !== e.addr) begin
         n_err++;
         $display("FAIL rd_prio_cmd got wr=%b addr=%h exp wr=%b addr=%h", w, a, e.wr, e.addr);
      end
      n_cmp++;
      if (l !== 9'd256) begin
         n_err++;
         $display("FAIL rd_prio_len got %0d exp 256", l);
      end
      n_cmp++;
      if (held !== 1'b1) begin
         n_err++;
         $display("FAIL rd_prio_hold got held=%b exp 1", held);
      end
      n_cmp++;
      if ({cmd_valid, busy} !== 2'b00) begin
         n_err++;
         $display("FAIL rearb_gap got valid=%b busy=%b exp 0 0", cmd_valid, busy);
      end
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd0;
   endtask

   task automatic test_write_frame_swap();
      logic got, w, held;
      logic [ADDR_W-1:0] a;
      logic [8:0] l;
      cmd_t e;
      int n;
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd256;
      for (int i = 0; i < 4; i++) begin
         sb.push_back({1'b1, 22'(i * BL)});
         serve(0, 1, got, w, a, l, held);
         e = sb.pop_front();
         n_cmp++;
         if (!got || w !== e.wr || a !== e.addr) begin
            n_err++;
            $display("FAIL wr_addr_%0d got wr=%b addr=%h exp wr=%b addr=%h", i, w, a, e.wr, e.addr);
         end
         n_cmp++;
         if (wr_frame_done !== (i == 3)) begin
            n_err++;
            $display("FAIL wr_frame_done_%0d got %b exp %b", i, wr_frame_done, (i == 3));
         end
      end
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wr_frame_done !== 1'b0 || cmd_valid !== 1'b0) n++;
      end
      n_cmp++;
      if (n !== 0) begin
         n_err++;
         $display("FAIL frame_full_quiet got %0d active cycles exp 0", n);
      end
      wr_fifo_level = 10'd0;
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      n_cmp++;
      if ({wr_bank, rd_bank} !== 2'b10) begin
         n_err++;
         $display("FAIL swap_banks got wr_bank=%b rd_bank=%b exp 1 0", wr_bank, rd_bank);
      end
      rd_fifo_space = 10'd512;
      sb.push_back({1'b0, 22'h000000});
      serve(0, 1, got, w, a, l, held);
      e = sb.pop_front();
      rd_fifo_space = 10'd100;
      n_cmp++;
      if (!got || w !== e.wr || a !== e.addr) begin
         n_err++;
         $display("FAIL swap_read got wr=%b addr=%h exp wr=%b addr=%h", w, a, e.wr, e.addr);
      end
   endtask

   task automatic test_sync_during_burst();
      logic got, w, held;
      logic [ADDR_W-1:0] a;
      logic [8:0] l;
      cmd_t e;
      int n;
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd256;
      for (int i = 0; i < 4; i++) begin
         sb.push_back({1'b1, 22'h200000 | 22'(i * BL)});
         serve(0, 1, got, w, a, l, held);
         e = sb.pop_front();
         n_cmp++;
         if (!got || w !== e.wr || a !== e.addr) begin
            n_err++;
            $display("FAIL bank1_wr_%0d got wr=%b addr=%h exp wr=%b addr=%h", i, w, a, e.wr, e.addr);
         end
      end
      wr_fifo_level = 10'd0; rd_fifo_space = 10'd512;
      sb.push_back({1'b0, 22'h000100});
      n = 0;
      while (cmd_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_wr !== e.wr || cmd_addr !== e.addr) begin
         n_err++;
         $display("FAIL wait_sync_read got valid=%b wr=%b addr=%h exp 1 %b %h", cmd_valid, cmd_wr, cmd_addr, e.wr, e.addr);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0; rd_fifo_space = 10'd100;
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({wr_bank, rd_bank, busy} !== 3'b101) begin
         n_err++;
         $display("FAIL sync_pending_banks got wr_bank=%b rd_bank=%b busy=%b exp 1 0 1", wr_bank, rd_bank, busy);
      end
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      n_cmp++;
      if ({wr_bank, rd_bank, busy} !== 3'b010) begin
         n_err++;
         $display("FAIL sync_applied_banks got wr_bank=%b rd_bank=%b busy=%b exp 0 1 0", wr_bank, rd_bank, busy);
      end
      rd_fifo_space = 10'd512;
      sb.push_back({1'b0, 22'h200000});
      serve(0, 1, got, w, a, l, held);
      e = sb.pop_front();
      rd_fifo_space = 10'd100;
      n_cmp++;
      if (!got || w !== e.wr || a !== e.addr) begin
         n_err++;
         $display("FAIL post_sync_read got wr=%b addr=%h exp wr=%b addr=%h", w, a, e.wr, e.addr);
      end
   endtask

   task automatic test_incomplete_frame();
      logic got, w, held;
      logic [ADDR_W-1:0] a;
      logic [8:0] l;
      cmd_t e;
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd256;
      for (int i = 0; i < 2; i++) begin
         sb.push_back({1'b1, 22'(i * BL)});
         serve(0, 1, got, w, a, l, held);
         e = sb.pop_front();
         n_cmp++;
         if (!got || w !== e.wr || a !== e.addr) begin
            n_err++;
            $display("FAIL partial_wr_%0d got wr=%b addr=%h exp wr=%b addr=%h", i, w, a, e.wr, e.addr);
         end
      end
      wr_fifo_level = 10'd0;
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      n_cmp++;
      if ({wr_bank, rd_bank} !== 2'b01) begin
         n_err++;
         $display("FAIL repeat_frame_banks got wr_bank=%b rd_bank=%b exp 0 1", wr_bank, rd_bank);
      end
      rd_fifo_space = 10'd512;
      sb.push_back({1'b0, 22'h200000});
      serve(0, 1, got, w, a, l, held);
      e = sb.pop_front();
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd256;
      n_cmp++;
      if (!got || w !== e.wr || a !== e.addr) begin
         n_err++;
         $display("FAIL repeat_read got wr=%b addr=%h exp wr=%b addr=%h", w, a, e.wr, e.addr);
      end
      sb.push_back({1'b1, 22'h000200});
      serve(0, 1, got, w, a, l, held);
      e = sb.pop_front();
      wr_fifo_level = 10'd0;
      n_cmp++;
      if (!got || w !== e.wr || a !== e.addr) begin
         n_err++;
         $display("FAIL continue_write got wr=%b addr=%h exp wr=%b addr=%h", w, a, e.wr, e.addr);
      end
   endtask

   // Both FIFOs stay eligible; write pointer starts at 768 in bank 0, read pointer at 256 in bank 1.
   task automatic test_starvation();
      logic got, w, held, pick_w;
      logic [ADDR_W-1:0] a;
      logic [8:0] l;
      cmd_t e;
      int cnt, rp, wp;
      cnt = 0; rp = 256; wp = 768;
      rd_fifo_space = 10'd512; wr_fifo_level = 10'd256;
      for (int k = 0; k < 6; k++) begin
`ifdef FRAME_SCHED_STARVE_GUARD_EN
         pick_w = (wp < FW) && (cnt >= 4);
`else
         pick_w = 1'b0;
`endif
         if (pick_w) begin
            sb.push_back({1'b1, 22'(wp)});
            wp = wp + BL;
            cnt = 0;
         end else begin
            sb.push_back({1'b0, 22'h200000 | 22'(rp)});
            cnt = (wp < FW) ? cnt + 1 : 0;
            rp = (rp + BL) % FW;
         end
         serve(0, 1, got, w, a, l, held);
         e = sb.pop_front();
         n_cmp++;
         if (!got || w !== e.wr || a !== e.addr) begin
            n_err++;
            $display("FAIL starve_grant_%0d got wr=%b addr=%h exp wr=%b addr=%h", k, w, a, e.wr, e.addr);
         end
      end
      rd_fifo_space = 10'd100; wr_fifo_level = 10'd0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_read_priority();
      test_write_frame_swap();
      test_sync_during_burst();
      test_incomplete_frame();
      test_starvation();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
